// File: rtl/text_line_ctrl.sv
// Text-line controller: holds a loadable message of character codes and, for
// every scanned pixel, reports which character cell covers it, that cell's
// glyph code and cell origin, so a shared set of glyph renderers can draw a
// whole line of text. Includes a valid/ready loader and frame-counted blink.
module text_line_ctrl #(
    parameter int MAX_LEN      = 16,
    parameter int CODE_W       = 5,
    parameter int ORIGIN_X     = 64,
    parameter int ORIGIN_Y     = 200,
    parameter int PITCH_LOG2   = 5,
    parameter int GLYPH_W      = 26,
    parameter int GLYPH_H      = 40,
    parameter int BLINK_FRAMES = 30
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              frame_start,
    input  logic              load_req,
    input  logic              wr_valid,
    input  logic [CODE_W-1:0] wr_code,
    input  logic              wr_last,
    output logic              wr_ready,
    input  logic              blink_en,
    output logic              cell_active,
    output logic [CODE_W-1:0] glyph_code,
    output logic [31:0]       char_start_x,
    output logic [31:0]       char_start_y,
    output logic [5:0]        msg_len,
    output logic              busy
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int CNT_W = $clog2(BLINK_FRAMES + 1);

    // Pixel comparisons are done at 11 bits so x below the origin cannot wrap
    // around into a small, apparently valid cell index.
    localparam logic [10:0]      ORG_X11  = 11'(ORIGIN_X);
    localparam logic [10:0]      Y_TOP11  = 11'(ORIGIN_Y);
    localparam logic [10:0]      Y_BOT11  = 11'(ORIGIN_Y + GLYPH_H);
    localparam logic [10:0]      GLYPH_W11 = 11'(GLYPH_W);
    localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(MAX_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SHOW = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [CODE_W-1:0] msg_buf [MAX_LEN];
    logic [IDX_W-1:0]  wr_ptr;
    logic              do_write;
    logic              do_commit;

    logic [CNT_W-1:0]  frame_cnt;
    logic              hidden;
    logic              visible;

    logic [10:0]           x_ext;
    logic [10:0]           y_ext;
    logic [10:0]           dx;
    logic [10:0]           idx_full;
    logic [PITCH_LOG2-1:0] col;
    logic                  in_cell;
    logic [CODE_W-1:0]     cell_code;
    logic [31:0]           cell_x;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, handshake strobes and loader status; load_req wins over a
    // coincident handshake so a restart never keeps a stale code.
    always_comb begin
        next_state = state;
        wr_ready   = 1'b0;
        busy       = 1'b0;
        do_write   = 1'b0;
        do_commit  = 1'b0;
        case (state)
            IDLE: begin
                if (load_req) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                wr_ready = 1'b1;
                busy     = 1'b1;
                if (load_req) begin
                    next_state = LOAD;
                end else if (wr_valid) begin
                    do_write = 1'b1;
                    if (wr_last || (wr_ptr == PTR_LAST)) begin
                        do_commit  = 1'b1;
                        next_state = SHOW;
                    end
                end
            end
            SHOW: begin
                if (load_req) begin
                    next_state = LOAD;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Write pointer and committed length; both restart on every load request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            msg_len <= '0;
        end else if (load_req) begin
            wr_ptr  <= '0;
            msg_len <= '0;
        end else if (do_write) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (do_commit) begin
                msg_len <= 6'(wr_ptr) + 6'd1;
            end
        end
    end

    // Message storage; contents need no reset because msg_len gates every read.
    always_ff @(posedge clk) begin
        if (do_write) begin
            msg_buf[wr_ptr] <= wr_code;
        end
    end

    // Blink timing: count frames, flip the hidden phase every BLINK_FRAMES.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            hidden    <= 1'b0;
        end else if (!blink_en || do_commit) begin
            frame_cnt <= '0;
            hidden    <= 1'b0;
        end else if (frame_start) begin
            if (frame_cnt == CNT_LAST) begin
                frame_cnt <= '0;
                hidden    <= ~hidden;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // Map the scan position onto a character cell of the message line.
    always_comb begin
        x_ext     = {1'b0, x};
        y_ext     = {1'b0, y};
        dx        = x_ext - ORG_X11;
        idx_full  = dx >> PITCH_LOG2;
        col       = dx[PITCH_LOG2-1:0];
        in_cell   = (x_ext >= ORG_X11)
                 && (idx_full < {5'd0, msg_len})
                 && (11'(col) < GLYPH_W11)
                 && (y_ext >= Y_TOP11)
                 && (y_ext < Y_BOT11);
        cell_code = msg_buf[idx_full[IDX_W-1:0]];
        cell_x    = 32'(ORIGIN_X) + (32'(idx_full) << PITCH_LOG2);
        visible   = !(blink_en && hidden);
    end

    // Registered renderer outputs, one pixel clock behind x/y.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cell_active  <= 1'b0;
            glyph_code   <= '0;
            char_start_x <= '0;
            char_start_y <= '0;
        end else if ((state == SHOW) && in_cell && visible) begin
            cell_active  <= 1'b1;
            glyph_code   <= cell_code;
            char_start_x <= cell_x;
            char_start_y <= 32'(ORIGIN_Y);
        end else begin
            cell_active  <= 1'b0;
            glyph_code   <= '0;
            char_start_x <= '0;
            char_start_y <= '0;
        end
    end

endmodule

// File: tb/tb_text_line_ctrl.sv
// Scoreboard bench for text_line_ctrl: stimulus pushes expected outputs into a
// queue, a monitor pops and compares when the matching response is due.
module tb_text_line_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        frame_start;
    logic        load_req;
    logic        wr_valid;
    logic [4:0]  wr_code;
    logic        wr_last;
    logic        wr_ready;
    logic        blink_en;
    logic        cell_active;
    logic [4:0]  glyph_code;
    logic [31:0] char_start_x;
    logic [31:0] char_start_y;
    logic [5:0]  msg_len;
    logic        busy;

    typedef struct {
        string       name;
        logic        act;
        logic [4:0]  code;
        logic [31:0] sx;
        logic [31:0] sy;
        logic [5:0]  len;
        logic        bsy;
        logic        rdy;
    } exp_t;

    exp_t       exp_q[$];
    int         tests_run    = 0;
    int         tests_failed = 0;
    logic       probe        = 1'b0;
    logic       probe_d      = 1'b0;
    logic [5:0] exp_len      = 6'd0;
    event       async_ev;

    always #5 clk = ~clk;

    text_line_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .x            (x),
        .y            (y),
        .frame_start  (frame_start),
        .load_req     (load_req),
        .wr_valid     (wr_valid),
        .wr_code      (wr_code),
        .wr_last      (wr_last),
        .wr_ready     (wr_ready),
        .blink_en     (blink_en),
        .cell_active  (cell_active),
        .glyph_code   (glyph_code),
        .char_start_x (char_start_x),
        .char_start_y (char_start_y),
        .msg_len      (msg_len),
        .busy         (busy)
    );

    // Pop one expectation and compare it with what the DUT presents now.
    task automatic compareOne();
        exp_t e;
        tests_run++;
        if (exp_q.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL scoreboard_underflow: got a response with no expectation, required a queued entry");
            return;
        end
        e = exp_q.pop_front();
        if (cell_active !== e.act || glyph_code !== e.code || char_start_x !== e.sx ||
            char_start_y !== e.sy || msg_len !== e.len || busy !== e.bsy || wr_ready !== e.rdy) begin
            tests_failed++;
            $display("[TB] FAIL %s: got act=%0b code=%0d sx=%0d sy=%0d len=%0d busy=%0b rdy=%0b, expected act=%0b code=%0d sx=%0d sy=%0d len=%0d busy=%0b rdy=%0b",
                     e.name, cell_active, glyph_code, char_start_x, char_start_y, msg_len, busy, wr_ready,
                     e.act, e.code, e.sx, e.sy, e.len, e.bsy, e.rdy);
        end
    endtask

    // A probe raised this cycle means the response is due after the next edge.
    always @(posedge clk) probe_d <= probe;

    // Clocked monitor samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (probe_d) compareOne();
    end

    // Unclocked monitor for the asynchronous-reset expectation.
    always begin
        @(async_ev);
        compareOne();
    end

    task automatic applyStimulus(input logic [9:0] xv, input logic [9:0] yv, input logic lr,
                                 input logic wv, input logic [4:0] wc, input logic wl, input logic fs);
        x           = xv;
        y           = yv;
        load_req    = lr;
        wr_valid    = wv;
        wr_code     = wc;
        wr_last     = wl;
        frame_start = fs;
    endtask

    task automatic checkOutput(input string nm, input logic a, input logic [4:0] c, input logic [31:0] sx,
                               input logic [5:0] len, input logic bsy, input logic rdy);
        exp_t e;
        e.name = nm;
        e.act  = a;
        e.code = c;
        e.sx   = sx;
        e.sy   = a ? 32'd200 : 32'd0;
        e.len  = len;
        e.bsy  = bsy;
        e.rdy  = rdy;
        exp_q.push_back(e);
        probe = 1'b1;
    endtask

    task automatic asyncCheck(input string nm);
        exp_t e;
        e.name = nm;
        e.act  = 1'b0;
        e.code = '0;
        e.sx   = '0;
        e.sy   = '0;
        e.len  = '0;
        e.bsy  = 1'b0;
        e.rdy  = 1'b0;
        exp_q.push_back(e);
        ->async_ev;
        #1;
    endtask

    task automatic cycle();
        @(negedge clk);
        probe = 1'b0;
    endtask

    // One idle pixel probe while a message is on show.
    task automatic pixCheck(input string nm, input logic [9:0] xv, input logic [9:0] yv,
                            input logic a, input logic [4:0] c, input logic [31:0] sx);
        applyStimulus(xv, yv, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        checkOutput(nm, a, c, sx, exp_len, 1'b0, 1'b0);
        cycle();
    endtask

    initial begin
        logic vis;
        rst_n    = 1'b0;
        blink_en = 1'b0;
        applyStimulus(10'd0, 10'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        cycle();
        asyncCheck("reset_state");
        rst_n = 1'b1;

        applyStimulus(10'd96, 10'd210, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        checkOutput("idle_no_display", 1'b0, 5'd0, 32'd0, 6'd0, 1'b0, 1'b0);
        cycle();

        // Reset in the middle of a load.
        applyStimulus(10'd96, 10'd210, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        checkOutput("load_enter", 1'b0, 5'd0, 32'd0, 6'd0, 1'b1, 1'b1);
        cycle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(10'd96, 10'd210, 1'b0, 1'b1, 5'(7 + i), 1'b0, 1'b0);
            checkOutput($sformatf("midload_hs%0d", i), 1'b0, 5'd0, 32'd0, 6'd0, 1'b1, 1'b1);
            cycle();
        end
        applyStimulus(10'd96, 10'd210, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        asyncCheck("reset_mid_load");
        cycle();
        rst_n = 1'b1;
        pixCheck("post_reset_x96", 10'd96, 10'd210, 1'b0, 5'd0, 32'd0);
        pixCheck("post_reset_x64", 10'd64, 10'd200, 1'b0, 5'd0, 32'd0);

        // Load {1,2,3} with wr_last on the third code.
        applyStimulus(10'd0, 10'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        checkOutput("load3_enter", 1'b0, 5'd0, 32'd0, 6'd0, 1'b1, 1'b1);
        cycle();
        applyStimulus(10'd0, 10'd0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0);
        checkOutput("load3_hs1", 1'b0, 5'd0, 32'd0, 6'd0, 1'b1, 1'b1);
        cycle();
        applyStimulus(10'd0, 10'd0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0);
        checkOutput("load3_hs2", 1'b0, 5'd0, 32'd0, 6'd0, 1'b1, 1'b1);
        cycle();
        applyStimulus(10'd96, 10'd210, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0);
        checkOutput("load3_commit", 1'b0, 5'd0, 32'd0, 6'd3, 1'b0, 1'b0);
        cycle();
        exp_len = 6'd3;
        pixCheck("show_x96", 10'd96, 10'd210, 1'b1, 5'd2, 32'd96);

        // Cell boundaries with a three-character message.
        pixCheck("col25_x89",       10'd89,   10'd210, 1'b1, 5'd1, 32'd64);
        pixCheck("col26_x90",       10'd90,   10'd210, 1'b0, 5'd0, 32'd0);
        pixCheck("left_x63",        10'd63,   10'd210, 1'b0, 5'd0, 32'd0);
        pixCheck("idx3_x160",       10'd160,  10'd210, 1'b0, 5'd0, 32'd0);
        pixCheck("idx2_x128",       10'd128,  10'd210, 1'b1, 5'd3, 32'd128);
        pixCheck("bottom_y239",     10'd64,   10'd239, 1'b1, 5'd1, 32'd64);
        pixCheck("below_y240",      10'd64,   10'd240, 1'b0, 5'd0, 32'd0);
        pixCheck("above_y199",      10'd64,   10'd199, 1'b0, 5'd0, 32'd0);
        pixCheck("top_y200",        10'd64,   10'd200, 1'b1, 5'd1, 32'd64);
        pixCheck("far_left_x0",     10'd0,    10'd210, 1'b0, 5'd0, 32'd0);
        pixCheck("far_right_x1023", 10'd1023, 10'd210, 1'b0, 5'd0, 32'd0);

        // Blinking: hidden for frames 30..59, visible again at frame 60.
        blink_en = 1'b1;
        pixCheck("blink_start", 10'd96, 10'd210, 1'b1, 5'd2, 32'd96);
        for (int k = 1; k <= 90; k++) begin
            applyStimulus(10'd96, 10'd210, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
            cycle();
            applyStimulus(10'd96, 10'd210, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
            vis = (k < 30) || (k >= 60 && k < 90);
            if (k == 1 || k == 29 || k == 30 || k == 45 || k == 59 || k == 60 || k == 90) begin
                checkOutput($sformatf("blink_frame%0d", k), vis, vis ? 5'd2 : 5'd0,
                            vis ? 32'd96 : 32'd0, 6'd3, 1'b0, 1'b0);
            end
            cycle();
        end
        blink_en = 1'b0;
        pixCheck("blink_off_restore", 10'd96, 10'd210, 1'b1, 5'd2, 32'd96);
        blink_en = 1'b1;
        pixCheck("blink_reenable", 10'd96, 10'd210, 1'b1, 5'd2, 32'd96);
        blink_en = 1'b0;

        // load_req coincident with a handshake drops that code.
        applyStimulus(10'd0, 10'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        checkOutput("coinc_enter", 1'b0, 5'd0, 32'd0, 6'd0, 1'b1, 1'b1);
        cycle();
        applyStimulus(10'd0, 10'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
        checkOutput("coinc_hs1", 1'b0, 5'd0, 32'd0, 6'd0, 1'b1, 1'b1);
        cycle();
        applyStimulus(10'd0, 10'd0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
        checkOutput("coinc_restart", 1'b0, 5'd0, 32'd0, 6'd0, 1'b1, 1'b1);
        cycle();
        applyStimulus(10'd0, 10'd0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0);
        checkOutput("coinc_commit_len1", 1'b0, 5'd0, 32'd0, 6'd1, 1'b0, 1'b0);
        cycle();
        exp_len = 6'd1;
        pixCheck("coinc_code4",    10'd64, 10'd210, 1'b1, 5'd4, 32'd64);
        pixCheck("coinc_idx1_off", 10'd96, 10'd210, 1'b0, 5'd0, 32'd0);

        // Overflow: twenty handshakes without wr_last, only sixteen accepted.
        applyStimulus(10'd0, 10'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        checkOutput("ovf_enter", 1'b0, 5'd0, 32'd0, 6'd0, 1'b1, 1'b1);
        cycle();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(10'd0, 10'd0, 1'b0, 1'b1, 5'(i + 10), 1'b0, 1'b0);
            checkOutput($sformatf("ovf_hs%0d", i), 1'b0, 5'd0, 32'd0,
                        (i >= 15) ? 6'd16 : 6'd0, (i < 15), (i < 15));
            cycle();
        end
        exp_len = 6'd16;
        pixCheck("ovf_idx15",     10'd544, 10'd210, 1'b1, 5'd25, 32'd544);
        pixCheck("ovf_idx0",      10'd64,  10'd210, 1'b1, 5'd10, 32'd64);
        pixCheck("ovf_idx16_off", 10'd576, 10'd210, 1'b0, 5'd0,  32'd0);

        applyStimulus(10'd0, 10'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        cycle();
        cycle();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL scoreboard_leftover: got %0d unchecked entries, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
